dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Memory-side responder for the load/store unit's data accesses.
- Holds a word-organised data RAM behind a valid/ready request channel and a valid/ready response channel.
- Supports per-byte write masks and a programmable number of wait states.
- The initiator aligns and splits accesses before issuing them. This block serves exactly one word-aligned transaction at a time and reports out-of-range addresses.

Parameters:
- DEPTH_WORDS, 512, number of 32-bit words; 512 covers byte range 0x000-0x7FF. Must be a power of 2.
- WAIT_CYCLES, 1, extra cycles between request accept and RAM access. Legal range 0..15.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  reset, asynchronous, active-high
- i_req_valid  input  1  request present
- o_req_ready  output  1  responder can accept a request
- i_req_addr  input  32  byte address; bits [1:0] ignored
- i_req_wren  input  1  1 = write, 0 = read
- i_req_bmask  input  4  byte enables for writes; bit k enables wdata[8k+7:8k]
- i_req_wdata  input  32  write data, already lane-aligned
- o_rsp_valid  output  1  response present
- i_rsp_ready  input  1  initiator accepts response
- o_rsp_rdata  output  32  read word
- o_rsp_err  output  1  address out of range

Behaviour:
- Clocking and reset:
  - Clock is i_clk. Reset is i_reset, asynchronous, active-high.
  - While in reset, and on the first cycle after release: state IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, wait counter=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - o_req_ready=1.
  - On an edge with i_req_valid=1: capture addr, wren, bmask and wdata into registers; load the 4-bit counter with WAIT_CYCLES; go to WAIT.
- WAIT:
  - o_req_ready=0. Counter decrements each edge while non-zero.
  - At the edge where counter==0, perform the access using the captured values and go to RESP.
- Access rules:
  - Word index = captured addr[log2(DEPTH_WORDS)+1:2].
  - In range (addr < DEPTH_WORDS*4), write: update only the bytes whose bmask bit is set. o_rsp_rdata <= 0, o_rsp_err <= 0. A write with bmask=0000 is a legal no-op.
  - In range, read: o_rsp_rdata <= the full stored word, independent of bmask. o_rsp_err <= 0.
  - Out of range: no RAM update. o_rsp_rdata <= 0, o_rsp_err <= 1.
- RESP:
  - o_rsp_valid=1 and o_req_ready=0.
  - o_rsp_rdata and o_rsp_err stay stable until the handshake.
  - On an edge with i_rsp_ready=1, go to IDLE; o_rsp_valid drops in the next cycle.
  - Holding i_rsp_ready=0 stalls RESP indefinitely.
- Latency and throughput:
  - Request accepted at edge N gives o_rsp_valid high after edge N+1+WAIT_CYCLES.
  - Minimum spacing between accepts is WAIT_CYCLES+3 cycles.
- Protocol boundaries:
  - i_req_valid is ignored while o_req_ready=0. No request is queued.
  - Request inputs may change after acceptance without effect, since captured copies are used.
  - i_rsp_ready is ignored outside RESP.
- Ordering:
  - A read issued after a completed write to the same word returns the written bytes merged with the old unmasked bytes. No stale data is returned.
- Reset mid-operation:
  - Assertion in WAIT discards the pending transaction, including a pending write; RAM is unchanged.
  - Assertion in RESP drops the response.
- Counter width is 4 bits. WAIT_CYCLES outside 0..15 is a parameter error flagged at elaboration.

Test Plan:
- Reset then idle -> o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
- WAIT_CYCLES=1: write addr 0x10, wdata 0xAABBCCDD, bmask 1111; read 0x10 -> rdata 0xAABBCCDD, err=0; rsp_valid rises exactly 2 edges after each accept.
- Byte masks: after the previous write, write 0x11223344 with bmask 0101 to 0x10; read 0x10 -> 0xAA22CC44. Write with bmask 0000 -> word unchanged.
- Out of range, DEPTH_WORDS=512: write 0x800 then read 0x800 -> both give err=1, rdata=0. Read 0x7FC -> err=0 and word 0 unchanged.
- Backpressure: hold i_rsp_ready=0 for 5 cycles in RESP while toggling i_req_valid and changing addr -> rsp data stable, req_ready=0, no new accept. Release -> IDLE next cycle.
- Reset mid-WAIT with WAIT_CYCLES=3: accept write 0xDEADBEEF to 0x20, assert i_reset after 1 cycle; read 0x20 afterwards -> prior contents returned, not 0xDEADBEEF. Sweep WAIT_CYCLES=0 and 15 -> latency 1 and 16 respectively.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind valid/ready request and response channels.
// It serves one transaction at a time, supports byte masks and fixed wait states, and flags out-of-range addresses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_wren,
    input  logic [3:0]  i_req_bmask,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("dmem_responder: WAIT_CYCLES must be in 0..15");
        end
        if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 || DEPTH_WORDS < 2) begin : g_bad_depth
            $error("dmem_responder: DEPTH_WORDS must be a power of 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [3:0]      wait_cnt;
    logic [31:0]     addr_q;
    logic            wren_q;
    logic [3:0]      bmask_q;
    logic [31:0]     wdata_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            in_range;
    logic [AW-1:0]   word_idx;
    logic            do_access;
    logic            do_write;

    assign in_range  = (addr_q < 32'(DEPTH_WORDS * 4));
    assign word_idx  = addr_q[AW+1:2];
    assign do_access = (state == WAIT) && (wait_cnt == 4'd0);
    assign do_write  = do_access && wren_q && in_range;

    // Captured request copies; later changes on the request inputs have no effect.
    always_ff @(posedge i_clk) begin
        if (state == IDLE && i_req_valid) begin
            addr_q  <= i_req_addr;
            wren_q  <= i_req_wren;
            bmask_q <= i_req_bmask;
            wdata_q <= i_req_wdata;
        end
    end

    // RAM contents survive reset, so the write port lives outside the reset domain.
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (bmask_q[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        wait_cnt    <= 4'(WAIT_CYCLES);
                        o_req_ready <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        o_rsp_valid <= 1'b1;
                        state       <= RESP;
                        if (!in_range) begin
                            o_rsp_rdata <= 32'd0;
                            o_rsp_err   <= 1'b1;
                        end else begin
                            o_rsp_rdata <= wren_q ? 32'd0 : mem[word_idx];
                            o_rsp_err   <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_req_ready <= 1'b1;
                    o_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
